// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO owner: 32-iteration multiply/divide sequencer with MTHI/MTLO
// writes and a pipeline stall while an operation is in flight.
module hilo_muldiv_ctrl #(
   parameter int          ITER  = 32,
   parameter logic [31:0] DZ_LO = 32'hFFFFFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   input  logic        hilo_rd,
   input  logic        flush,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        busy,
   output logic        done,
   output logic        dz,
   output logic        stall
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic [CW-1:0] cnt;
   logic          is_div;
   logic          neg_res;
   logic          neg_rem;
   logic          dz_q;
   logic [31:0]   acc_hi;
   logic [31:0]   acc_lo;
   logic [31:0]   opb;

   logic          load;
   logic          step;
   logic          wr_fin;
   logic          mt_ok;

   logic          sgn;
   logic [31:0]   mag_a;
   logic [31:0]   mag_b;
   logic [32:0]   mul_sum;
   logic [32:0]   div_sh;
   logic [33:0]   div_df;
   logic [63:0]   prod;
   logic [63:0]   prod_fix;
   logic [31:0]   quo_fix;
   logic [31:0]   rem_fix;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // next-state: flush aborts both a pending launch and an op in flight
   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: if (start && !flush) state_nx = S_RUN;
         S_RUN: begin
            if (flush)                          state_nx = S_IDLE;
            else if (cnt == CW'(ITER - 1))      state_nx = S_FIN;
         end
         S_FIN:   state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // output decode: busy plus datapath enables
   always_comb begin
      busy   = 1'b0;
      load   = 1'b0;
      step   = 1'b0;
      wr_fin = 1'b0;
      mt_ok  = 1'b0;
      unique case (state)
         S_IDLE: begin
            load  = start & ~flush;
            mt_ok = ~start;
         end
         S_RUN: begin
            busy = 1'b1;
            step = ~flush;
         end
         S_FIN: begin
            busy   = 1'b1;
            wr_fin = ~flush;
         end
         default: ;
      endcase
      stall = busy & (hilo_rd | start | mthi | mtlo);
   end

   // operand magnitudes and per-iteration arithmetic
   always_comb begin
      sgn     = ~op[0];
      mag_a   = (sgn & rs_val[31]) ? -rs_val : rs_val;
      mag_b   = (sgn & rt_val[31]) ? -rt_val : rt_val;
      mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
      div_sh  = {acc_hi, acc_lo[31]};
      div_df  = {1'b0, div_sh} - {2'b00, opb};
      prod    = {acc_hi, acc_lo};
      prod_fix = neg_res ? -prod : prod;
      quo_fix  = neg_res ? -acc_lo : acc_lo;
      rem_fix  = neg_rem ? -acc_hi : acc_hi;
   end

   // shift-add multiply / restoring divide datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_res <= 1'b0;
         neg_rem <= 1'b0;
         dz_q    <= 1'b0;
         acc_hi  <= '0;
         acc_lo  <= '0;
         opb     <= '0;
      end else if (load) begin
         cnt     <= '0;
         is_div  <= op[1];
         neg_res <= sgn & (rs_val[31] ^ rt_val[31]);
         neg_rem <= sgn & rs_val[31];
         dz_q    <= op[1] & (rt_val == 32'd0);
         acc_hi  <= '0;
         acc_lo  <= op[1] ? mag_a : mag_b;
         opb     <= op[1] ? mag_b : mag_a;
      end else if (step) begin
         cnt <= cnt + 1'b1;
         if (is_div) begin
            acc_lo <= {acc_lo[30:0], ~div_df[33]};
            acc_hi <= div_df[33] ? div_sh[31:0] : div_df[31:0];
         end else begin
            {acc_hi, acc_lo} <= {mul_sum, acc_lo[31:1]};
         end
      end
   end

   // architectural HI/LO: op results or MTHI/MTLO writes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         HI <= '0;
         LO <= '0;
      end else if (wr_fin) begin
         if (is_div) begin
            HI <= rem_fix;
            LO <= dz_q ? DZ_LO : quo_fix;
         end else begin
            {HI, LO} <= prod_fix;
         end
      end else if (mt_ok) begin
         if (mthi) HI <= wdata;
         if (mtlo) LO <= wdata;
      end
   end

   // completion pulses for the cycle after the result write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         done <= 1'b0;
         dz   <= 1'b0;
      end else begin
         done <= wr_fin;
         dz   <= wr_fin & dz_q;
      end
   end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl: directed cases plus random
// traffic compared every cycle against a cycle-count behavioural model.
module tb_hilo_muldiv_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        hilo_rd;
   logic        flush;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        busy;
   logic        done;
   logic        dz;
   logic        stall;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   int          m_cnt  = 0;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;
   logic        m_done = 1'b0;
   logic        m_dz   = 1'b0;
   logic [31:0] r_hi   = '0;
   logic [31:0] r_lo   = '0;
   logic        r_dz   = 1'b0;

   hilo_muldiv_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op),
      .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
      .wdata(wdata), .hilo_rd(hilo_rd), .flush(flush),
      .HI(HI), .LO(LO), .busy(busy), .done(done), .dz(dz),
      .stall(stall)
   );

   always #5 clk = ~clk;

   // reference result {dz, HI, LO} from plain arithmetic
   function automatic logic [64:0] ref_res(input logic [1:0] o,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      longint          sa, sb, p, q, r;
      longint unsigned ua, ub, up, uq, ur;
      logic [64:0]     res;
      res = '0;
      sa = $signed(a);
      sb = $signed(b);
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         2'b00: begin
            p   = sa * sb;
            res = {1'b0, p[63:0]};
         end
         2'b01: begin
            up  = ua * ub;
            res = {1'b0, up[63:0]};
         end
         2'b10: begin
            if (b == 32'd0) res = {1'b1, a, 32'hFFFFFFFF};
            else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {1'b0, r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'd0) res = {1'b1, a, 32'hFFFFFFFF};
            else begin
               uq  = ua / ub;
               ur  = ua % ub;
               res = {1'b0, ur[31:0], uq[31:0]};
            end
         end
      endcase
      return res;
   endfunction

   // model: an op occupies 33 busy cycles, results land on the 34th edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cnt  <= 0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_done <= 1'b0;
         m_dz   <= 1'b0;
      end else begin
         m_done <= 1'b0;
         m_dz   <= 1'b0;
         if (m_cnt == 0) begin
            if (start && !flush) begin
               {r_dz, r_hi, r_lo} <= ref_res(op, rs_val, rt_val);
               m_cnt <= 1;
            end else if (!start) begin
               if (mthi) m_hi <= wdata;
               if (mtlo) m_lo <= wdata;
            end
         end else if (flush) begin
            m_cnt <= 0;
         end else if (m_cnt == 33) begin
            m_hi   <= r_hi;
            m_lo   <= r_lo;
            m_done <= 1'b1;
            m_dz   <= r_dz;
            m_cnt  <= 0;
         end else begin
            m_cnt <= m_cnt + 1;
         end
      end
   end

   task automatic chk(input string nm, input logic [67:0] act,
                      input logic [67:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cycle",
             {HI, LO, busy, done, dz, stall},
             {m_hi, m_lo, (m_cnt != 0), m_done, m_dz,
              ((m_cnt != 0) && (hilo_rd || start || mthi || mtlo))});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_op(input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, output int bcy,
                        output bit got_done, output bit got_dz);
      start  = 1'b1;
      op     = o;
      rs_val = a;
      rt_val = b;
      tick();
      start    = 1'b0;
      bcy      = 0;
      got_done = 1'b0;
      got_dz   = 1'b0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            got_done = 1'b1;
            got_dz   = dz;
            break;
         end
         if (busy) bcy++;
      end
   endtask

   task automatic run_chk(input string nm, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input bit edz);
      int bcy;
      bit gd;
      bit gz;
      do_op(o, a, b, bcy, gd, gz);
      chk({nm, "_busy_cycles"}, 68'(bcy), 68'(33));
      chk({nm, "_done"}, 68'(gd), 68'(1));
      chk({nm, "_dz"}, 68'(gz), 68'(edz));
      chk({nm, "_hilo"}, 68'({HI, LO}), 68'({eh, el}));
      tick();
   endtask

   initial begin
      int nd;
      rst_n   = 1'b0;
      start   = 1'b0;
      op      = 2'b00;
      rs_val  = '0;
      rt_val  = '0;
      mthi    = 1'b0;
      mtlo    = 1'b0;
      wdata   = '0;
      hilo_rd = 1'b0;
      flush   = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      chk_en = 1'b1;
      @(negedge clk);
      chk("reset_state", 68'({HI, LO, busy, done, dz}), 68'(0));
      tick();

      run_chk("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'h5,
              32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
      run_chk("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h00000001, 1'b0);
      run_chk("divu_100_7", 2'b11, 32'd100, 32'd7,
              32'd2, 32'd14, 1'b0);
      run_chk("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      run_chk("div_by_zero", 2'b10, 32'h00001234, 32'd0,
              32'h00001234, 32'hFFFFFFFF, 1'b1);
      run_chk("div_min_neg1", 2'b10, 32'h80000000, 32'hFFFFFFFF,
              32'h0, 32'h80000000, 1'b0);

      // stall and ignored MTLO during a MULTU
      start  = 1'b1;
      op     = 2'b01;
      rs_val = 32'h12345678;
      rt_val = 32'h10;
      tick();
      start = 1'b0;
      repeat (9) tick();
      hilo_rd = 1'b1;
      mtlo    = 1'b1;
      wdata   = 32'hDEADBEEF;
      repeat (5) tick();
      @(negedge clk);
      chk("stall_mid", 68'(stall), 68'(1));
      tick();
      mtlo = 1'b0;
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) begin
            nd = 1;
            break;
         end
      end
      chk("stall_done_seen", 68'(nd), 68'(1));
      chk("stall_done_cycle", 68'({done, stall}), 68'(2'b10));
      chk("multu_mtlo_ignored", 68'({HI, LO}),
          68'({32'h00000001, 32'h23456780}));
      tick();
      hilo_rd = 1'b0;

      // flush a DIV after loading HI
      mthi  = 1'b1;
      wdata = 32'hAAAA5555;
      tick();
      mthi   = 1'b0;
      start  = 1'b1;
      op     = 2'b10;
      rs_val = 32'd100;
      rt_val = 32'd3;
      tick();
      start = 1'b0;
      repeat (4) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("flush_idle", 68'({busy, done, HI}), 68'({2'b00, 32'hAAAA5555}));
      nd = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) nd++;
      end
      chk("flush_no_done", 68'(nd), 68'(0));
      tick();
      run_chk("after_flush", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);

      // asynchronous reset in the middle of a MULTU
      start  = 1'b1;
      op     = 2'b01;
      rs_val = 32'hFFFFFFFF;
      rt_val = 32'hFFFFFFFF;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst_n = 1'b0;
      #1;
      chk("reset_async", 68'({HI, LO, busy}), 68'(0));
      tick();
      rst_n = 1'b1;
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'h12345678;
      tick();
      mthi = 1'b0;
      mtlo = 1'b0;
      @(negedge clk);
      chk("mt_both", 68'({HI, LO}), 68'({32'h12345678, 32'h12345678}));
      tick();

      // random traffic checked by the per-cycle compare
      for (int i = 0; i < 1500; i++) begin
         start   = ($urandom_range(7) == 0);
         op      = 2'($urandom_range(3));
         rs_val  = $urandom;
         rt_val  = $urandom;
         if ($urandom_range(5) == 0) rt_val = 32'd0;
         if ($urandom_range(7) == 0) rs_val = 32'h80000000;
         if ($urandom_range(7) == 0) rt_val = 32'hFFFFFFFF;
         if ($urandom_range(9) == 0) rt_val = 32'($urandom_range(9));
         mthi    = ($urandom_range(9) == 0);
         mtlo    = ($urandom_range(9) == 0);
         wdata   = $urandom;
         hilo_rd = ($urandom_range(2) == 0);
         flush   = ($urandom_range(59) == 0);
         tick();
      end
      start   = 1'b0;
      mthi    = 1'b0;
      mtlo    = 1'b0;
      hilo_rd = 1'b0;
      flush   = 1'b0;
      repeat (40) tick();

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hilo_muldiv_ctrl.md
Name: hilo_muldiv_ctrl

Overview:
Multicycle multiply/divide sequencer that owns the architectural HI/LO registers. Their outputs feed the HI and LO inputs of the operand-2 selector. It runs MULT/MULTU/DIV/DIVU as a 32-iteration shift-add/restoring-divide datapath, services MTHI/MTLO writes, and raises a pipeline stall when HI/LO are accessed while an operation is in flight.

Parameters:
ITER, 32, iteration count; equals operand width; fixed for 32-bit datapath
DZ_LO, 32'hFFFFFFFF, LO value written on divide-by-zero

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch op in decode/execute; sampled only in IDLE
op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
rs_val  in  32  multiplicand / dividend
rt_val  in  32  multiplier / divisor
mthi  in  1  write wdata to HI
mtlo  in  1  write wdata to LO
wdata  in  32  MTHI/MTLO data
hilo_rd  in  1  MFHI/MFLO or operand-2 HI/LO select active this cycle
flush  in  1  synchronous abort of in-flight op
HI  out  32  architectural HI
LO  out  32  architectural LO
busy  out  1  op in flight
done  out  1  one-cycle pulse, results written
dz  out  1  one-cycle pulse with done, divide by zero occurred
stall  out  1  hold pipeline

Behaviour:
- Reset (async, rst_n=0): state=IDLE, HI=LO=0, busy=done=dz=0, counter=0, internal accumulators=0. Asserting reset mid-op aborts the op immediately; HI/LO are 0 after release.
- States: IDLE, RUN, FIN.
- IDLE: start=1 at edge E0 latches op, magnitudes |rs|,|rt| (signed ops) or raw values (unsigned), result-sign flags, and a dz flag (divide op and rt_val==0); counter=0; ->RUN.
- RUN: one iteration per edge, E1..E32; counter increments; at counter==ITER-1 ->FIN.
- FIN: at edge E33, apply sign correction and write HI/LO; ->IDLE. done=1 (and dz if latched) for the single cycle after E33.
- busy=1 for exactly 33 cycles (after E0 through before E33 completes); registered, state!=IDLE.
- Multiply: 64-bit product {HI,LO}. Signed: negate the product when the operand signs differ. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=FFFFFFFE, LO=00000001.
- Divide: LO=quotient, HI=remainder; truncate toward zero; remainder sign = dividend sign. DIV 0x80000000 / 0xFFFFFFFF -> LO=80000000, HI=0, no flag.
- Divide by zero: full 33-cycle latency kept; HI=rs_val as latched, LO=DZ_LO; dz pulses with done.
- MTHI/MTLO in IDLE with start=0: written at that edge; both may assert together (same wdata to both).
- start together with mthi/mtlo in IDLE: start wins, writes dropped.
- start, mthi or mtlo while busy: ignored; stall covers them.
- stall = busy & (hilo_rd | start | mthi | mtlo); combinational. Deasserts in the done cycle, when HI/LO are already valid.
- flush while busy: ->IDLE at next edge; HI/LO unchanged; no done. flush in IDLE: no effect. flush and start together in IDLE: start ignored.
- done and dz are never asserted outside the cycle after FIN.

Test Plan:
- MULT rs=FFFFFFFD (-3), rt=00000005 -> busy high 33 cycles, done in cycle 34, HI=FFFFFFFF, LO=FFFFFFF1.
- DIVU rs=100, rt=7 -> LO=14, HI=2; DIV rs=FFFFFFF9 (-7), rt=2 -> LO=FFFFFFFD, HI=FFFFFFFF.
- DIV rs=00001234, rt=0 -> done and dz pulse together, HI=00001234, LO=FFFFFFFF.
- hilo_rd=1 at cycle 10 of a MULTU -> stall=1 until the done cycle; mtlo during busy leaves LO unchanged.
- flush at cycle 5 of a DIV after mthi loaded HI=AAAA5555 -> returns to IDLE, HI=AAAA5555, no done; a new start is then accepted.
- rst_n low at cycle 20 of a MULTU -> HI=LO=0, busy=0 immediately; after release, mthi+mtlo with wdata=12345678 -> HI=LO=12345678.
